axi_lite_arbiter_rr: RTL and testbench
======================================

# axi_lite_arbiter_rr

Round-robin arbiter that shares one AXI4-Lite slave port between `NUM_SLV` AXI4-Lite requesters, such as protocol-converted AXI masters, debug bridges and DMA config ports. Read and write directions are arbitrated independently. Each direction has at most one outstanding transaction. AW and W are presented to the slave simultaneously, for Xilinx AXI-Lite slave compatibility. The block sits between the AXI-to-AXI-Lite converters and the shared peripheral/config bus.

## Interface
- `NUM_SLV`, default 4: number of requester ports, legal range 2..8.
- `ADDR_WIDTH`, default 32: address width A.
- `DATA_WIDTH`, default 32: data width D, either 32 or 64. Strobe width is D/8.
- Reset is synchronous and active-low. One clock.
- `Clk_CI` in, 1: clock.
- `Rst_RBI` in, 1: synchronous active-low reset.
- `Slv_AwAddr_DI` in N*A, `Slv_AwValid_SI` in N, `Slv_AwReady_SO` out N: requester AW channels, packed with port k at slice k.
- `Slv_WData_DI` in N*D, `Slv_WStrb_DI` in N*D/8, `Slv_WValid_SI` in N, `Slv_WReady_SO` out N: requester W channels.
- `Slv_BResp_DO` out N*2, `Slv_BValid_SO` out N, `Slv_BReady_SI` in N: requester B channels.
- `Slv_ArAddr_DI` in N*A, `Slv_ArValid_SI` in N, `Slv_ArReady_SO` out N: requester AR channels.
- `Slv_RData_DO` out N*D, `Slv_RResp_DO` out N*2, `Slv_RValid_SO` out N, `Slv_RReady_SI` in N: requester R channels.
- `Mst_AwAddr_DO`, `Mst_AwValid_SO`, `Mst_AwReady_SI`: shared AW channel.
- `Mst_WData_DO`, `Mst_WStrb_DO`, `Mst_WValid_SO`, `Mst_WReady_SI`: shared W channel.
- `Mst_BResp_DI`, `Mst_BValid_DI`, `Mst_BReady_SO`: shared B channel.
- `Mst_ArAddr_DO`, `Mst_ArValid_SO`, `Mst_ArReady_SI`: shared AR channel.
- `Mst_RData_DI`, `Mst_RResp_DI`, `Mst_RValid_SI`, `Mst_RReady_SO`: shared R channel.

## Operation
- **Write request.** Port k requests a write when `Slv_AwValid_SI[k] && Slv_WValid_SI[k]`. AW alone does not request.
- **Write FSM, W_IDLE.** On any request, pick a grant `WGnt` (round-robin), register it, and go to W_XFER.
- **Write FSM, W_XFER.** Mux the address, data and strobe of `WGnt` onto the master port.
  - `Mst_AwValid_SO = !AwDone`; `Mst_WValid_SO = !WDone`.
  - An AW handshake sets `AwDone` and pulses `Slv_AwReady_SO[WGnt]` in the same cycle.
  - A W handshake sets `WDone` and pulses `Slv_WReady_SO[WGnt]` in the same cycle.
  - AW and W may fire in the same cycle or in either order.
  - When both are done, clear the flags and go to W_RESP.
- **Write FSM, W_RESP.**
  - `Mst_BReady_SO = Slv_BReady_SI[WGnt]`.
  - `Slv_BValid_SO[WGnt] = Mst_BValid_DI`. `Slv_BResp_DO[WGnt] = Mst_BResp_DI`.
  - On the B handshake, go to W_IDLE.
- **Read request.** Port k requests a read when `Slv_ArValid_SI[k]`.
- **Read FSM, R_IDLE.** On any request, pick `RGnt`, register it, and go to R_ADDR.
- **Read FSM, R_ADDR.** `Mst_ArValid_SO = 1` with `Slv_ArAddr_DI[RGnt]`. An AR handshake pulses `Slv_ArReady_SO[RGnt]` and goes to R_DATA.
- **Read FSM, R_DATA.** Route R between the master and `RGnt` as in W_RESP. On the R handshake, go to R_IDLE.
- **Round-robin.**
  - Each direction has its own pointer P, reset to 0.
  - The grant is the first requesting port searched from P upward, wrapping modulo `NUM_SLV`.
  - After a grant to g, P = (g+1) mod `NUM_SLV`.
- **Non-granted ports.** All ready/valid outputs are 0. Data/resp outputs for non-granted ports are 0.
- **Master outputs when not in a transfer state.** Valid signals are 0; address, data and strobe are 0.
- **Direction independence.** Read and write FSMs run concurrently. A read and a write may be outstanding at the same time, from the same or different ports.
- **Requester rules.** Requesters must hold valid until the handshake (AXI rule). Deasserting valid before the handshake is undefined; no check is made.

## Timing
- **Reset.** Both FSMs go to IDLE, both pointers to 0, `AwDone`/`WDone` to 0, and every valid/ready output is 0.
- **Reset mid-transaction.** The transaction is abandoned; no B/R is delivered.
- **Grant latency.** A request seen in IDLE in cycle t gives master valid in cycle t+1. Best-case transaction is 3 cycles for both reads and writes (IDLE, XFER/ADDR, RESP/DATA).
- **No combinational paths.** There is no path from a requester valid to `Mst_*Valid`. Ready and valid are passed combinationally between master and granted requester only in the XFER, RESP, ADDR and DATA states.
- **Back-to-back.** There is no bubble beyond the IDLE cycle: B handshake at t, IDLE at t+1, next master valid at t+2.
- **Simultaneous requests.** A request that arrives at the same time as the pointer update uses the updated pointer in the next IDLE cycle.

## Configuration
- **`AXI_LITE_ARB_FIXED_PRIO_EN` defined.** Both directions use fixed priority: the lowest index wins. Pointers are not implemented.
- **Undefined (default).** Round-robin as specified above.

## Test plan
- **Single write.** Port 2 writes addr 0x40, data 0xDEADBEEF, strb 0xF; slave ready at once.
  - Master AW/W valid 1 cycle after the request, with matching address, data and strobe.
  - `Slv_BValid_SO[2]` carries resp 0; no other port sees any activity.
- **Split AW/W.** Slave asserts `Mst_WReady_SI` 2 cycles before `Mst_AwReady_SI`.
  - `Mst_WValid_SO` drops after the W handshake while AW stays valid.
  - Exactly one `Slv_WReady_SO[k]` pulse and one `Slv_AwReady_SO[k]` pulse.
- **Round-robin fairness.** All 4 ports request reads continuously.
  - Grant order is 0,1,2,3,0,1,...
  - With `AXI_LITE_ARB_FIXED_PRIO_EN` defined, port 0 wins every time.
- **Concurrent directions.** Port 1 reads 0x10 while port 3 writes 0x20.
  - Both are outstanding together.
  - R is returned only to port 1 and B only to port 3.
  - Slave error resp 2'b10 on R is passed through unchanged.
- **Backpressure.** `Slv_RReady_SI[0]` is held low 5 cycles while `Mst_RValid_SI` is high. `Mst_RReady_SO` stays 0 for those 5 cycles, then completes.
- **Reset mid-transaction.** `Rst_RBI` goes low in W_RESP. The next cycle shows all outputs 0 and the FSM in W_IDLE; the first grant after reset goes to port 0.

Source files
------------

// File: rtl/axi_lite_arbiter_rr.sv
// Round-robin arbiter sharing one AXI4-Lite slave between NUM_SLV requesters, reads and writes arbitrated independently.
// Define AXI_LITE_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority in both directions.
module axi_lite_arbiter_rr #(
  parameter int unsigned NUM_SLV    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                              Clk_CI,
  input  logic                              Rst_RBI,
  // Requester side, port k at slice k
  input  logic [NUM_SLV*ADDR_WIDTH-1:0]     Slv_AwAddr_DI,
  input  logic [NUM_SLV-1:0]                Slv_AwValid_SI,
  output logic [NUM_SLV-1:0]                Slv_AwReady_SO,
  input  logic [NUM_SLV*DATA_WIDTH-1:0]     Slv_WData_DI,
  input  logic [NUM_SLV*DATA_WIDTH/8-1:0]   Slv_WStrb_DI,
  input  logic [NUM_SLV-1:0]                Slv_WValid_SI,
  output logic [NUM_SLV-1:0]                Slv_WReady_SO,
  output logic [NUM_SLV*2-1:0]              Slv_BResp_DO,
  output logic [NUM_SLV-1:0]                Slv_BValid_SO,
  input  logic [NUM_SLV-1:0]                Slv_BReady_SI,
  input  logic [NUM_SLV*ADDR_WIDTH-1:0]     Slv_ArAddr_DI,
  input  logic [NUM_SLV-1:0]                Slv_ArValid_SI,
  output logic [NUM_SLV-1:0]                Slv_ArReady_SO,
  output logic [NUM_SLV*DATA_WIDTH-1:0]     Slv_RData_DO,
  output logic [NUM_SLV*2-1:0]              Slv_RResp_DO,
  output logic [NUM_SLV-1:0]                Slv_RValid_SO,
  input  logic [NUM_SLV-1:0]                Slv_RReady_SI,
  // Shared slave side
  output logic [ADDR_WIDTH-1:0]             Mst_AwAddr_DO,
  output logic                              Mst_AwValid_SO,
  input  logic                              Mst_AwReady_SI,
  output logic [DATA_WIDTH-1:0]             Mst_WData_DO,
  output logic [DATA_WIDTH/8-1:0]           Mst_WStrb_DO,
  output logic                              Mst_WValid_SO,
  input  logic                              Mst_WReady_SI,
  input  logic [1:0]                        Mst_BResp_DI,
  input  logic                              Mst_BValid_DI,
  output logic                              Mst_BReady_SO,
  output logic [ADDR_WIDTH-1:0]             Mst_ArAddr_DO,
  output logic                              Mst_ArValid_SO,
  input  logic                              Mst_ArReady_SI,
  input  logic [DATA_WIDTH-1:0]             Mst_RData_DI,
  input  logic [1:0]                        Mst_RResp_DI,
  input  logic                              Mst_RValid_SI,
  output logic                              Mst_RReady_SO,
  // FSM state observation (0 idle, 1 xfer/addr, 2 resp/data)
  output logic [1:0]                        Dbg_WState_SO,
  output logic [1:0]                        Dbg_RState_SO
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_SLV);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_e;

  // Handshakes: a beat transfers in a cycle where valid and ready are both high;
  // valid never depends combinationally on ready, and ready/valid pass through
  // only between the master and the registered grant in non-idle states.

  w_state_e           wstate_q, wstate_d;
  r_state_e           rstate_q, rstate_d;
  logic [IDX_W-1:0]   wgnt_q, wgnt_d, rgnt_q, rgnt_d;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic               aw_hs, w_hs;
  logic [NUM_SLV-1:0] wreq, rreq;
  logic [IDX_W-1:0]   wpick, rpick;
  int unsigned        wsel, rsel;

  assign wreq = Slv_AwValid_SI & Slv_WValid_SI;
  assign rreq = Slv_ArValid_SI;
  assign wsel = 32'(wgnt_q);
  assign rsel = 32'(rgnt_q);

  assign Dbg_WState_SO = wstate_q;
  assign Dbg_RState_SO = rstate_q;

`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
  function automatic logic [IDX_W-1:0] prio_pick(input logic [NUM_SLV-1:0] req);
    logic [IDX_W-1:0] gnt;
    gnt = '0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if (req[i]) gnt = IDX_W'(i);
    end
    return gnt;
  endfunction

  always_comb begin
    wpick = prio_pick(wreq);
    rpick = prio_pick(rreq);
  end
`else
  logic [IDX_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SLV-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] gnt;
    logic             found;
    int unsigned      idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_SLV) idx = idx - NUM_SLV;
      if (!found && req[idx]) begin
        gnt   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] gnt);
    if (32'(gnt) == NUM_SLV - 1) return '0;
    return gnt + 1'b1;
  endfunction

  always_comb begin
    wpick  = rr_pick(wreq, wptr_q);
    rpick  = rr_pick(rreq, rptr_q);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wstate_q == W_IDLE && |wreq) wptr_d = ptr_after(wpick);
    if (rstate_q == R_IDLE && |rreq) rptr_d = ptr_after(rpick);
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`endif

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wgnt_q    <= '0;
      rgnt_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wgnt_q    <= wgnt_d;
      rgnt_q    <= rgnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    wstate_d       = wstate_q;
    wgnt_d         = wgnt_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    Mst_AwAddr_DO  = '0;
    Mst_AwValid_SO = 1'b0;
    Mst_WData_DO   = '0;
    Mst_WStrb_DO   = '0;
    Mst_WValid_SO  = 1'b0;
    Mst_BReady_SO  = 1'b0;
    Slv_AwReady_SO = '0;
    Slv_WReady_SO  = '0;
    Slv_BValid_SO  = '0;
    Slv_BResp_DO   = '0;
    case (wstate_q)
      W_IDLE: begin
        if (|wreq) begin
          wgnt_d   = wpick;
          wstate_d = W_XFER;
        end
      end
      W_XFER: begin
        Mst_AwAddr_DO  = Slv_AwAddr_DI[wsel*ADDR_WIDTH +: ADDR_WIDTH];
        Mst_WData_DO   = Slv_WData_DI[wsel*DATA_WIDTH +: DATA_WIDTH];
        Mst_WStrb_DO   = Slv_WStrb_DI[wsel*STRB_WIDTH +: STRB_WIDTH];
        Mst_AwValid_SO = !aw_done_q;
        Mst_WValid_SO  = !w_done_q;
        aw_hs          = !aw_done_q && Mst_AwReady_SI;
        w_hs           = !w_done_q && Mst_WReady_SI;
        Slv_AwReady_SO[wgnt_q] = aw_hs;
        Slv_WReady_SO[wgnt_q]  = w_hs;
        // AW and W complete independently; leave only once both have fired.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      W_RESP: begin
        Mst_BReady_SO                 = Slv_BReady_SI[wgnt_q];
        Slv_BValid_SO[wgnt_q]         = Mst_BValid_DI;
        Slv_BResp_DO[wsel*2 +: 2]     = Mst_BResp_DI;
        if (Mst_BValid_DI && Slv_BReady_SI[wgnt_q]) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d       = rstate_q;
    rgnt_d         = rgnt_q;
    Mst_ArAddr_DO  = '0;
    Mst_ArValid_SO = 1'b0;
    Mst_RReady_SO  = 1'b0;
    Slv_ArReady_SO = '0;
    Slv_RValid_SO  = '0;
    Slv_RData_DO   = '0;
    Slv_RResp_DO   = '0;
    case (rstate_q)
      R_IDLE: begin
        if (|rreq) begin
          rgnt_d   = rpick;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        Mst_ArAddr_DO          = Slv_ArAddr_DI[rsel*ADDR_WIDTH +: ADDR_WIDTH];
        Mst_ArValid_SO         = 1'b1;
        Slv_ArReady_SO[rgnt_q] = Mst_ArReady_SI;
        if (Mst_ArReady_SI) rstate_d = R_DATA;
      end
      R_DATA: begin
        Mst_RReady_SO                            = Slv_RReady_SI[rgnt_q];
        Slv_RValid_SO[rgnt_q]                    = Mst_RValid_SI;
        Slv_RData_DO[rsel*DATA_WIDTH +: DATA_WIDTH] = Mst_RData_DI;
        Slv_RResp_DO[rsel*2 +: 2]                = Mst_RResp_DI;
        if (Mst_RValid_SI && Slv_RReady_SI[rgnt_q]) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter_rr.sv
// Directed self-checking bench for axi_lite_arbiter_rr with 4 ports, 32-bit address and data.
module tb_axi_lite_arbiter_rr;

  logic          clk;
  logic          rst_n;
  logic [127:0]  slv_aw_addr, slv_w_data, slv_ar_addr, slv_r_data;
  logic [15:0]   slv_w_strb;
  logic [3:0]    slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready;
  logic [3:0]    slv_b_valid, slv_b_ready, slv_ar_valid, slv_ar_ready;
  logic [3:0]    slv_r_valid, slv_r_ready;
  logic [7:0]    slv_b_resp, slv_r_resp;
  logic [31:0]   mst_aw_addr, mst_w_data, mst_ar_addr, mst_r_data;
  logic [3:0]    mst_w_strb;
  logic          mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready;
  logic          mst_b_valid, mst_b_ready, mst_ar_valid, mst_ar_ready;
  logic          mst_r_valid, mst_r_ready;
  logic [1:0]    mst_b_resp, mst_r_resp;
  logic [1:0]    dbg_w, dbg_r;
  logic [268:0]  all_out;

  int errors = 0;
  int checks = 0;

  axi_lite_arbiter_rr #(.NUM_SLV(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Slv_AwAddr_DI(slv_aw_addr), .Slv_AwValid_SI(slv_aw_valid), .Slv_AwReady_SO(slv_aw_ready),
    .Slv_WData_DI(slv_w_data), .Slv_WStrb_DI(slv_w_strb), .Slv_WValid_SI(slv_w_valid),
    .Slv_WReady_SO(slv_w_ready),
    .Slv_BResp_DO(slv_b_resp), .Slv_BValid_SO(slv_b_valid), .Slv_BReady_SI(slv_b_ready),
    .Slv_ArAddr_DI(slv_ar_addr), .Slv_ArValid_SI(slv_ar_valid), .Slv_ArReady_SO(slv_ar_ready),
    .Slv_RData_DO(slv_r_data), .Slv_RResp_DO(slv_r_resp), .Slv_RValid_SO(slv_r_valid),
    .Slv_RReady_SI(slv_r_ready),
    .Mst_AwAddr_DO(mst_aw_addr), .Mst_AwValid_SO(mst_aw_valid), .Mst_AwReady_SI(mst_aw_ready),
    .Mst_WData_DO(mst_w_data), .Mst_WStrb_DO(mst_w_strb), .Mst_WValid_SO(mst_w_valid),
    .Mst_WReady_SI(mst_w_ready),
    .Mst_BResp_DI(mst_b_resp), .Mst_BValid_DI(mst_b_valid), .Mst_BReady_SO(mst_b_ready),
    .Mst_ArAddr_DO(mst_ar_addr), .Mst_ArValid_SO(mst_ar_valid), .Mst_ArReady_SI(mst_ar_ready),
    .Mst_RData_DI(mst_r_data), .Mst_RResp_DI(mst_r_resp), .Mst_RValid_SI(mst_r_valid),
    .Mst_RReady_SO(mst_r_ready),
    .Dbg_WState_SO(dbg_w), .Dbg_RState_SO(dbg_r)
  );

  assign all_out = {mst_aw_addr, mst_aw_valid, mst_w_data, mst_w_strb, mst_w_valid, mst_b_ready,
                    mst_ar_addr, mst_ar_valid, mst_r_ready, slv_aw_ready, slv_w_ready, slv_b_resp,
                    slv_b_valid, slv_ar_ready, slv_r_data, slv_r_resp, slv_r_valid};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    slv_aw_addr = '0; slv_aw_valid = '0; slv_w_data = '0; slv_w_strb = '0; slv_w_valid = '0;
    slv_b_ready = '0; slv_ar_addr = '0; slv_ar_valid = '0; slv_r_ready = '0;
    mst_aw_ready = 1'b0; mst_w_ready = 1'b0; mst_b_resp = '0; mst_b_valid = 1'b0;
    mst_ar_ready = 1'b0; mst_r_data = '0; mst_r_resp = '0; mst_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) cyc();
    #1;
    checks++; if ({dbg_w, dbg_r} !== 4'b0000) begin errors++;
      $display("FAIL reset_state: got w=%0d r=%0d, want 0 0", dbg_w, dbg_r); end
    checks++; if (all_out !== '0) begin errors++;
      $display("FAIL reset_outputs: got %h, want 0", all_out); end
    slv_aw_valid = 4'hF; slv_w_valid = 4'hF; slv_ar_valid = 4'hF;
    cyc(); #1;
    checks++; if ({dbg_w, dbg_r, mst_aw_valid, mst_ar_valid} !== 6'b0) begin errors++;
      $display("FAIL reset_holds: got w=%0d r=%0d awv=%b arv=%b, want idle", dbg_w, dbg_r,
               mst_aw_valid, mst_ar_valid); end
    clear_inputs();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_write();
    clear_inputs();
    slv_aw_addr[64 +: 32] = 32'h40; slv_w_data[64 +: 32] = 32'hDEADBEEF; slv_w_strb[8 +: 4] = 4'hF;
    slv_aw_valid = 4'b0100; slv_w_valid = 4'b0100; slv_b_ready = 4'b0100;
    mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
    #1;
    checks++; if ({mst_aw_valid, mst_w_valid} !== 2'b00) begin errors++;
      $display("FAIL sw_no_comb_path: got awv/wv=%b, want 00", {mst_aw_valid, mst_w_valid}); end
    cyc(); #1;
    checks++; if ({mst_aw_valid, mst_w_valid, mst_aw_addr, mst_w_data, mst_w_strb} !==
                  {2'b11, 32'h40, 32'hDEADBEEF, 4'hF}) begin errors++;
      $display("FAIL sw_master_beat: got v=%b a=%h d=%h s=%h, want 11 40 deadbeef f",
               {mst_aw_valid, mst_w_valid}, mst_aw_addr, mst_w_data, mst_w_strb); end
    checks++; if ({slv_aw_ready, slv_w_ready} !== 8'b0100_0100) begin errors++;
      $display("FAIL sw_slv_ready: got aw=%b w=%b, want 0100 0100", slv_aw_ready, slv_w_ready); end
    cyc();
    slv_aw_valid = '0; slv_w_valid = '0; mst_b_valid = 1'b1; mst_b_resp = 2'b00;
    #1;
    checks++; if ({dbg_w, slv_b_valid, slv_b_resp, mst_b_ready, mst_aw_valid} !==
                  {2'd2, 4'b0100, 8'h00, 1'b1, 1'b0}) begin errors++;
      $display("FAIL sw_bresp: got st=%0d bv=%b br=%h brdy=%b awv=%b, want 2 0100 00 1 0",
               dbg_w, slv_b_valid, slv_b_resp, mst_b_ready, mst_aw_valid); end
    cyc();
    mst_b_valid = 1'b0;
    #1;
    checks++; if ({dbg_w, slv_b_valid} !== 6'b00_0000) begin errors++;
      $display("FAIL sw_done: got st=%0d bv=%b, want 0 0000", dbg_w, slv_b_valid); end
  endtask

  task automatic test_split_aw_w();
    int aw_pulses;
    int w_pulses;
    aw_pulses = 0;
    w_pulses  = 0;
    clear_inputs();
    slv_aw_addr[32 +: 32] = 32'h84; slv_w_data[32 +: 32] = 32'h5A5A; slv_w_strb[4 +: 4] = 4'h3;
    slv_aw_valid = 4'b0010; slv_w_valid = 4'b0010; slv_b_ready = 4'b0010;
    cyc();
    mst_w_ready = 1'b1;
    #1;
    checks++; if ({mst_aw_valid, mst_w_valid, slv_w_ready, slv_aw_ready} !== {2'b11, 4'b0010, 4'b0000})
      begin errors++;
      $display("FAIL split_w_first: got v=%b wr=%b awr=%b, want 11 0010 0000",
               {mst_aw_valid, mst_w_valid}, slv_w_ready, slv_aw_ready); end
    aw_pulses += $countones(slv_aw_ready); w_pulses += $countones(slv_w_ready);
    cyc();
    slv_w_valid = '0;
    #1;
    checks++; if ({mst_aw_valid, mst_w_valid} !== 2'b10) begin errors++;
      $display("FAIL split_w_dropped: got awv/wv=%b, want 10", {mst_aw_valid, mst_w_valid}); end
    aw_pulses += $countones(slv_aw_ready); w_pulses += $countones(slv_w_ready);
    cyc();
    mst_aw_ready = 1'b1;
    #1;
    checks++; if ({mst_aw_valid, mst_w_valid, mst_aw_addr, slv_aw_ready} !== {2'b10, 32'h84, 4'b0010})
      begin errors++;
      $display("FAIL split_aw_late: got v=%b a=%h awr=%b, want 10 84 0010",
               {mst_aw_valid, mst_w_valid}, mst_aw_addr, slv_aw_ready); end
    aw_pulses += $countones(slv_aw_ready); w_pulses += $countones(slv_w_ready);
    cyc();
    slv_aw_valid = '0; mst_aw_ready = 1'b0; mst_w_ready = 1'b0;
    mst_b_valid = 1'b1; mst_b_resp = 2'b11;
    #1;
    aw_pulses += $countones(slv_aw_ready); w_pulses += $countones(slv_w_ready);
    checks++; if ({slv_b_valid, slv_b_resp} !== {4'b0010, 8'b0000_1100}) begin errors++;
      $display("FAIL split_bresp: got bv=%b br=%b, want 0010 00001100", slv_b_valid, slv_b_resp); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (dbg_w !== 2'd0) begin errors++;
      $display("FAIL split_idle: got st=%0d, want 0", dbg_w); end
    checks++; if (aw_pulses !== 1 || w_pulses !== 1) begin errors++;
      $display("FAIL split_pulses: got aw=%0d w=%0d, want 1 1", aw_pulses, w_pulses); end
  endtask

  task automatic test_rr_fairness();
    int          exp_g;
    logic [127:0] exp_rd;
    clear_inputs();
    for (int k = 0; k < 4; k++) slv_ar_addr[k*32 +: 32] = 32'h100 + 32'(k * 4);
    slv_ar_valid = 4'hF; mst_ar_ready = 1'b1; mst_r_valid = 1'b1; slv_r_ready = 4'hF;
    #1;
    checks++; if ({dbg_r, mst_ar_valid} !== 3'b000) begin errors++;
      $display("FAIL rr_start_idle: got st=%0d arv=%b, want 0 0", dbg_r, mst_ar_valid); end
    for (int i = 0; i < 6; i++) begin
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 4;
`endif
      cyc(); #1;
      checks++; if (slv_ar_ready !== (4'b0001 << exp_g) || mst_ar_addr !== 32'h100 + 32'(exp_g * 4))
        begin errors++;
        $display("FAIL rr_grant[%0d]: got arr=%b a=%h, want port %0d", i, slv_ar_ready, mst_ar_addr,
                 exp_g); end
      cyc();
      mst_r_data = 32'hA000_0000 + 32'(i);
      exp_rd = '0;
      exp_rd[exp_g*32 +: 32] = 32'hA000_0000 + 32'(i);
      #1;
      checks++; if (slv_r_valid !== (4'b0001 << exp_g) || slv_r_data !== exp_rd) begin errors++;
        $display("FAIL rr_rdata[%0d]: got rv=%b d=%h, want port %0d d=%h", i, slv_r_valid, slv_r_data,
                 exp_g, exp_rd); end
      if (i == 5) slv_ar_valid = '0;
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_concurrent();
    clear_inputs();
    slv_ar_addr[32 +: 32] = 32'h10; slv_ar_valid = 4'b0010;
    slv_aw_addr[96 +: 32] = 32'h20; slv_w_data[96 +: 32] = 32'hCAFEF00D; slv_w_strb[12 +: 4] = 4'hF;
    slv_aw_valid = 4'b1000; slv_w_valid = 4'b1000;
    mst_aw_ready = 1'b1; mst_w_ready = 1'b1; mst_ar_ready = 1'b1;
    cyc(); #1;
    checks++; if ({mst_ar_addr, mst_aw_addr, slv_ar_ready, slv_aw_ready, dbg_w, dbg_r} !==
                  {32'h10, 32'h20, 4'b0010, 4'b1000, 2'd1, 2'd1}) begin errors++;
      $display("FAIL cc_addr: got ar=%h aw=%h arr=%b awr=%b st=%0d/%0d, want 10 20 0010 1000 1/1",
               mst_ar_addr, mst_aw_addr, slv_ar_ready, slv_aw_ready, dbg_w, dbg_r); end
    cyc();
    slv_ar_valid = '0; slv_aw_valid = '0; slv_w_valid = '0;
    mst_r_valid = 1'b1; mst_r_resp = 2'b10; mst_r_data = 32'h12345678;
    mst_b_valid = 1'b1; mst_b_resp = 2'b00; slv_r_ready = 4'b0010; slv_b_ready = 4'b1000;
    #1;
    checks++; if ({dbg_w, dbg_r} !== 4'b1010) begin errors++;
      $display("FAIL cc_both_outstanding: got st=%0d/%0d, want 2/2", dbg_w, dbg_r); end
    checks++; if ({slv_r_valid, slv_r_resp, slv_r_data} !==
                  {4'b0010, 8'b0000_1000, 32'h0, 32'h0, 32'h12345678, 32'h0}) begin errors++;
      $display("FAIL cc_r_route: got rv=%b rr=%b d=%h, want 0010 00001000 port1=12345678",
               slv_r_valid, slv_r_resp, slv_r_data); end
    checks++; if ({slv_b_valid, mst_b_ready, mst_r_ready} !== {4'b1000, 2'b11}) begin errors++;
      $display("FAIL cc_b_route: got bv=%b brdy=%b rrdy=%b, want 1000 1 1", slv_b_valid,
               mst_b_ready, mst_r_ready); end
    cyc();
    clear_inputs();
    #1;
    checks++; if ({dbg_w, dbg_r} !== 4'b0000) begin errors++;
      $display("FAIL cc_idle: got st=%0d/%0d, want 0/0", dbg_w, dbg_r); end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    slv_ar_addr[0 +: 32] = 32'h30; slv_ar_valid = 4'b0001; mst_ar_ready = 1'b1;
    cyc(); #1;
    checks++; if (slv_ar_ready !== 4'b0001) begin errors++;
      $display("FAIL bp_grant: got arr=%b, want 0001", slv_ar_ready); end
    cyc();
    slv_ar_valid = '0; mst_ar_ready = 1'b0; mst_r_valid = 1'b1; mst_r_data = 32'h0BADCAFE;
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++; if ({mst_r_ready, slv_r_valid, dbg_r} !== {1'b0, 4'b0001, 2'd2}) begin errors++;
        $display("FAIL bp_hold[%0d]: got rrdy=%b rv=%b st=%0d, want 0 0001 2", j, mst_r_ready,
                 slv_r_valid, dbg_r); end
      cyc();
    end
    slv_r_ready = 4'b0001;
    #1;
    checks++; if (mst_r_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release: got rrdy=%b, want 1", mst_r_ready); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (dbg_r !== 2'd0) begin errors++;
      $display("FAIL bp_done: got st=%0d, want 0", dbg_r); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    slv_aw_addr[0 +: 32] = 32'h50; slv_w_data[0 +: 32] = 32'h11; slv_w_strb[0 +: 4] = 4'hF;
    slv_aw_valid = 4'b0001; slv_w_valid = 4'b0001;
    mst_aw_ready = 1'b1; mst_w_ready = 1'b1; mst_b_valid = 1'b1; slv_b_ready = 4'b0001;
    cyc(); #1;
    checks++; if (mst_aw_valid !== 1'b1) begin errors++;
      $display("FAIL b2b_first: got awv=%b, want 1", mst_aw_valid); end
    cyc(); #1;
    checks++; if ({slv_b_valid, mst_b_ready} !== 5'b0001_1) begin errors++;
      $display("FAIL b2b_bhs: got bv=%b brdy=%b, want 0001 1", slv_b_valid, mst_b_ready); end
    cyc(); #1;
    checks++; if ({dbg_w, mst_aw_valid} !== 3'b000) begin errors++;
      $display("FAIL b2b_idle: got st=%0d awv=%b, want 0 0", dbg_w, mst_aw_valid); end
    cyc(); #1;
    checks++; if ({mst_aw_valid, mst_w_valid, slv_aw_ready} !== 6'b11_0001) begin errors++;
      $display("FAIL b2b_second: got v=%b awr=%b, want 11 0001", {mst_aw_valid, mst_w_valid},
               slv_aw_ready); end
    cyc();
    slv_aw_valid = '0; slv_w_valid = '0;
    cyc();
    clear_inputs();
    #1;
    checks++; if (dbg_w !== 2'd0) begin errors++;
      $display("FAIL b2b_done: got st=%0d, want 0", dbg_w); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    slv_aw_addr[0 +: 32] = 32'h70; slv_aw_valid = 4'b0001; slv_w_valid = 4'b0001;
    mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
    cyc();
    cyc();
    slv_aw_valid = '0; slv_w_valid = '0; mst_b_valid = 1'b1;
    #1;
    checks++; if ({dbg_w, slv_b_valid} !== {2'd2, 4'b0001}) begin errors++;
      $display("FAIL rm_in_resp: got st=%0d bv=%b, want 2 0001", dbg_w, slv_b_valid); end
    rst_n = 1'b0;
    cyc(); #1;
    checks++; if ({dbg_w, dbg_r} !== 4'b0000 || all_out !== '0) begin errors++;
      $display("FAIL rm_after_reset: got st=%0d/%0d out=%h, want 0/0 all zero", dbg_w, dbg_r,
               all_out); end
    rst_n = 1'b1;
    mst_b_valid = 1'b0;
    slv_aw_addr[0 +: 32] = 32'h60; slv_aw_addr[32 +: 32] = 32'h64;
    slv_aw_valid = 4'b0011; slv_w_valid = 4'b0011;
    cyc(); #1;
    checks++; if ({slv_aw_ready, mst_aw_addr} !== {4'b0001, 32'h60}) begin errors++;
      $display("FAIL rm_first_grant: got awr=%b a=%h, want 0001 60", slv_aw_ready, mst_aw_addr); end
    cyc();
    slv_aw_valid = '0; slv_w_valid = '0; mst_b_valid = 1'b1; slv_b_ready = 4'b0001;
    cyc();
    clear_inputs();
    #1;
    checks++; if (dbg_w !== 2'd0) begin errors++;
      $display("FAIL rm_done: got st=%0d, want 0", dbg_w); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_split_aw_w();
    test_rr_fairness();
    test_concurrent();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
